// File: rtl/conv_pkg.sv
// Shared widths, geometry, memory bases, FSM states and the output saturator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package conv_pkg;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 9;
    localparam int OUT_ADDR_W  = 3;
    localparam int ACC_W       = 36;

    localparam int IMG_DIM     = 8;
    localparam int Q_DIM       = 4;
    localparam int K_DIM       = 3;
    localparam int NUM_FILTERS = 2;

    localparam int NUM_WEIGHTS = NUM_FILTERS * K_DIM * K_DIM;
    localparam int Q_WORDS     = Q_DIM * Q_DIM;

    // Word bases of the three memories.
    localparam int BVM_BASE    = 0;
    localparam int DIM_BASE    = 0;
    localparam int DOM_BASE    = 0;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 36'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -36'sd32768;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_Q,
        S_COMPUTE,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    // Clamp a wide accumulator to signed 16 bits.
    function automatic logic [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)
            return 16'h7FFF;
        else if (v < SAT_MIN)
            return 16'h8000;
        else
            return v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/conv_pool_input_cache.sv
// Quadrant register file: fetches the 16 pixels of the current quadrant from dim.
// Latency: 16 addresses on consecutive cycles, last word captured one cycle later (17 cycles).
// Backpressure: none; the dim memory always answers with fixed 1-cycle read latency.
module input_cache
    import conv_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        restart,
    input  logic                        load,
    input  logic                        advance,
    input  logic [DATA_W-1:0]           dim_data,
    output logic [ADDR_W-1:0]           dim_address,
    output logic                        dim_enable,
    output logic [Q_WORDS*DATA_W-1:0]   pixels,
    output logic                        load_done,
    output logic [1:0]                  input_quadrant_index,
    output logic                        a0_cached
);

    logic [4:0]        cnt;
    logic [1:0]        quad;
    logic [DATA_W-1:0] mem [Q_WORDS];
    logic [2:0]        row;
    logic [2:0]        col;

    // Quadrant q starts at row 4*(q>>1), col 4*(q&1); cnt walks it row-major.
    assign row = {quad[1], cnt[3:2]};
    assign col = {quad[0], cnt[1:0]};

    assign dim_enable           = load && (cnt < 5'd16);
    assign dim_address          = dim_enable ? (ADDR_W'(DIM_BASE) + {3'b000, row, col}) : '0;
    assign load_done            = load && (cnt == 5'd16);
    assign input_quadrant_index = quad;

    for (genvar i = 0; i < Q_WORDS; i++) begin : g_pix
        assign pixels[i*DATA_W +: DATA_W] = mem[i];
    end

    // Issue counter, quadrant index and capture of read data one cycle behind the address.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            quad      <= '0;
            a0_cached <= 1'b0;
            for (int i = 0; i < Q_WORDS; i++) mem[i] <= '0;
        end else if (restart) begin
            cnt       <= '0;
            quad      <= '0;
            a0_cached <= 1'b0;
        end else if (advance) begin
            cnt       <= '0;
            quad      <= quad + 2'd1;
            a0_cached <= 1'b0;
        end else if (load) begin
            if (cnt != 5'd0) mem[cnt[3:0] - 4'd1] <= dim_data;
            if (cnt == 5'd1) a0_cached <= 1'b1;
            cnt <= load_done ? 5'd0 : cnt + 5'd1;
        end
    end

endmodule

// File: rtl/conv_pool_top.sv
// Conv 3x3 + ReLU (CONV_RELU_EN) + 2x2 max-pool over four 8x8-image quadrants, two filters.
// Latency: about 131 cycles from go to finish (19 weight load + 4 x 28 per quadrant).
// Backpressure: none; memories have fixed 1-cycle read latency, go ignored while busy.
module conv_pool_top
    import conv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        xxx__dut__go,
    output logic        dut__xxx__finish,
    output logic [8:0]  dut__bvm__address,
    output logic        dut__bvm__enable,
    output logic        dut__bvm__write,
    output logic [15:0] dut__bvm__data,
    input  logic [15:0] bvm__dut__data,
    output logic [8:0]  dut__dim__address,
    output logic        dut__dim__enable,
    output logic        dut__dim__write,
    output logic [15:0] dut__dim__data,
    input  logic [15:0] dim__dut__data,
    output logic [2:0]  dut__dom__address,
    output logic [15:0] dut__dom__data,
    output logic        dut__dom__enable,
    output logic        dut__dom__write
);

    state_t                      state;
    logic [4:0]                  cnt;
    logic signed [DATA_W-1:0]    w [NUM_WEIGHTS];
    logic signed [DATA_W-1:0]    px [Q_WORDS];
    logic [Q_WORDS*DATA_W-1:0]   pixels;
    logic signed [ACC_W-1:0]     best;
    logic [DATA_W-1:0]           res [NUM_FILTERS];

    logic                        restart;
    logic                        load;
    logic                        advance;
    logic                        load_done;
    logic [1:0]                  quad;
    logic                        a0_cached;

    logic                        f_sel;
    logic                        oy;
    logic                        ox;
    logic [4:0]                  wi;
    logic [3:0]                  pi;
    logic signed [2*DATA_W-1:0]  prod;
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     conv_val;
    logic signed [ACC_W-1:0]     cand;

    assign dut__bvm__write = 1'b0;
    assign dut__bvm__data  = '0;
    assign dut__dim__write = 1'b0;
    assign dut__dim__data  = '0;

    assign restart = (state == S_IDLE) && xxx__dut__go;
    assign load    = (state == S_LOAD_Q);
    assign advance = (state == S_NEXT);

    input_cache m2 (
        .clk                  (clk),
        .reset                (reset),
        .restart              (restart),
        .load                 (load),
        .advance              (advance),
        .dim_data             (dim__dut__data),
        .dim_address          (dut__dim__address),
        .dim_enable           (dut__dim__enable),
        .pixels               (pixels),
        .load_done            (load_done),
        .input_quadrant_index (quad),
        .a0_cached            (a0_cached)
    );

    for (genvar i = 0; i < Q_WORDS; i++) begin : g_px
        assign px[i] = pixels[i*DATA_W +: DATA_W];
    end

    // COMPUTE step cnt[2:0] selects filter and the (oy,ox) output position of the 2x2 window.
    assign f_sel = cnt[2];
    assign oy    = cnt[1];
    assign ox    = cnt[0];

    // One full 3x3 dot product per cycle.
    always_comb begin
        acc  = '0;
        wi   = '0;
        pi   = '0;
        prod = '0;
        for (int ky = 0; ky < K_DIM; ky++) begin
            for (int kx = 0; kx < K_DIM; kx++) begin
                wi   = 5'(f_sel ? 9 : 0) + 5'(ky * K_DIM + kx);
                pi   = 4'((int'(oy) + ky) * Q_DIM + int'(ox) + kx);
                prod = w[wi] * px[pi];
                acc  = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
            end
        end
    end

    // Optional ReLU, then running max; the first position of each window restarts the max.
    always_comb begin
        conv_val = acc;
`ifdef CONV_RELU_EN
        if (acc[ACC_W-1]) conv_val = '0;
`endif
        if ((cnt[1:0] == 2'd0) || (conv_val > best))
            cand = conv_val;
        else
            cand = best;
    end

    // Main sequencer with registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            cnt               <= '0;
            best              <= '0;
            dut__xxx__finish  <= 1'b0;
            dut__bvm__address <= '0;
            dut__bvm__enable  <= 1'b0;
            dut__dom__address <= '0;
            dut__dom__data    <= '0;
            dut__dom__enable  <= 1'b0;
            dut__dom__write   <= 1'b0;
            for (int i = 0; i < NUM_WEIGHTS; i++) w[i] <= '0;
            for (int i = 0; i < NUM_FILTERS; i++) res[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xxx__dut__go) begin
                        state             <= S_LOAD_W;
                        cnt               <= '0;
                        dut__xxx__finish  <= 1'b0;
                        dut__bvm__address <= ADDR_W'(BVM_BASE);
                        dut__bvm__enable  <= 1'b1;
                    end
                end
                S_LOAD_W: begin
                    if (cnt != 5'd0) w[cnt - 5'd1] <= bvm__dut__data;
                    if (cnt < 5'd17) begin
                        dut__bvm__address <= ADDR_W'(BVM_BASE) + {4'b0000, cnt + 5'd1};
                        dut__bvm__enable  <= 1'b1;
                    end else begin
                        dut__bvm__address <= '0;
                        dut__bvm__enable  <= 1'b0;
                    end
                    if (cnt == 5'd18) begin
                        state <= S_LOAD_Q;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_LOAD_Q: begin
                    if (load_done && a0_cached) begin
                        state <= S_COMPUTE;
                        cnt   <= '0;
                    end
                end
                S_COMPUTE: begin
                    best <= cand;
                    if (cnt[1:0] == 2'd3) res[cnt[2]] <= sat16(cand);
                    if (cnt == 5'd7) begin
                        state             <= S_WRITE;
                        cnt               <= '0;
                        dut__dom__enable  <= 1'b1;
                        dut__dom__write   <= 1'b1;
                        dut__dom__address <= OUT_ADDR_W'(DOM_BASE) + {1'b0, quad};
                        dut__dom__data    <= res[0];
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_WRITE: begin
                    if (cnt == 5'd0) begin
                        cnt               <= 5'd1;
                        dut__dom__address <= OUT_ADDR_W'(DOM_BASE) + {1'b1, quad};
                        dut__dom__data    <= res[1];
                    end else begin
                        cnt              <= '0;
                        state            <= S_NEXT;
                        dut__dom__enable <= 1'b0;
                        dut__dom__write  <= 1'b0;
                        if (quad == 2'd3) dut__xxx__finish <= 1'b1;
                    end
                end
                S_NEXT: begin
                    state <= (quad == 2'd3) ? S_DONE : S_LOAD_Q;
                end
                S_DONE: begin
                    dut__xxx__finish <= 1'b1;
                    state            <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pool_top.sv
// Directed bench for conv_pool_top with behavioural bvm/dim/dom memories.
// Expected values are hand-computed per vector; CONV_RELU_EN selects the ReLU variants.
module tb_conv_pool_top;

    logic        clk;
    logic        reset;
    logic        xxx__dut__go;
    logic        dut__xxx__finish;
    logic [8:0]  dut__bvm__address;
    logic        dut__bvm__enable;
    logic        dut__bvm__write;
    logic [15:0] dut__bvm__data;
    logic [15:0] bvm__dut__data;
    logic [8:0]  dut__dim__address;
    logic        dut__dim__enable;
    logic        dut__dim__write;
    logic [15:0] dut__dim__data;
    logic [15:0] dim__dut__data;
    logic [2:0]  dut__dom__address;
    logic [15:0] dut__dom__data;
    logic        dut__dom__enable;
    logic        dut__dom__write;

    conv_pool_top dut (
        .clk               (clk),
        .reset             (reset),
        .xxx__dut__go      (xxx__dut__go),
        .dut__xxx__finish  (dut__xxx__finish),
        .dut__bvm__address (dut__bvm__address),
        .dut__bvm__enable  (dut__bvm__enable),
        .dut__bvm__write   (dut__bvm__write),
        .dut__bvm__data    (dut__bvm__data),
        .bvm__dut__data    (bvm__dut__data),
        .dut__dim__address (dut__dim__address),
        .dut__dim__enable  (dut__dim__enable),
        .dut__dim__write   (dut__dim__write),
        .dut__dim__data    (dut__dim__data),
        .dim__dut__data    (dim__dut__data),
        .dut__dom__address (dut__dom__address),
        .dut__dom__data    (dut__dom__data),
        .dut__dom__enable  (dut__dom__enable),
        .dut__dom__write   (dut__dom__write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous 1-cycle-read memories (filter_ram behaviour) and dom capture.
    logic [15:0] bvm_mem [512];
    logic [15:0] dim_mem [512];
    logic [15:0] dom_mem [8];
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (dut__bvm__enable) bvm__dut__data <= bvm_mem[dut__bvm__address];
        if (dut__dim__enable) dim__dut__data <= dim_mem[dut__dim__address];
        if (dut__dom__enable && dut__dom__write) begin
            dom_mem[dut__dom__address] <= dut__dom__data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    typedef struct {
        string             name;
        logic [17:0][15:0] w;
        logic              ramp;
        logic [15:0]       pix;
        logic              busy_go;
        logic [7:0][15:0]  exp;
    } vec_t;

    vec_t vecs [5];

    function automatic logic idle_bad();
        return |{dut__bvm__address, dut__bvm__enable, dut__bvm__write, dut__bvm__data,
                 dut__dim__address, dut__dim__enable, dut__dim__write, dut__dim__data,
                 dut__dom__address, dut__dom__data, dut__dom__enable, dut__dom__write,
                 dut__xxx__finish};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int k);
        int   cycles;
        int   base;
        logic prev_en;
        for (int i = 0; i < 18; i++) bvm_mem[i] = vecs[k].w[i];
        for (int i = 0; i < 64; i++) dim_mem[i] = vecs[k].ramp ? 16'(i) : vecs[k].pix;
        base = wr_cnt;
        xxx__dut__go = 1'b1;
        tick();
        xxx__dut__go = 1'b0;
        chk({vecs[k].name, "_finish_drop"}, {31'd0, dut__xxx__finish}, 32'd0);
        cycles  = 1;
        prev_en = 1'b0;
        while (cycles < 300 && !dut__xxx__finish) begin
            xxx__dut__go = vecs[k].busy_go && (cycles == 40 || cycles == 100);
            prev_en = dut__dom__enable;
            tick();
            cycles++;
        end
        xxx__dut__go = 1'b0;
        chk({vecs[k].name, "_finish_rise"}, {31'd0, dut__xxx__finish}, 32'd1);
        chk({vecs[k].name, "_cycles_le_140"}, {31'd0, (cycles <= 140)}, 32'd1);
        chk({vecs[k].name, "_finish_after_write"}, {31'd0, prev_en}, 32'd1);
        chk({vecs[k].name, "_write_count"}, 32'(wr_cnt - base), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_dom%0d", vecs[k].name, i), {16'd0, dom_mem[i]}, {16'd0, vecs[k].exp[i]});
        tick();
        tick();
        chk({vecs[k].name, "_finish_hold"}, {31'd0, dut__xxx__finish}, 32'd1);
    endtask

    initial begin
        int e_id [8];
        int e_cn [8];
        int bound;
        e_id = '{18, 22, 50, 54, 0, 0, 0, 0};
`ifdef CONV_RELU_EN
        e_cn = '{9, 13, 41, 45, 0, 0, 0, 0};
`else
        e_cn = '{9, 13, 41, 45, 32'hFFDC, 32'hFFD4, 32'hFF9C, 32'hFF94};
`endif

        // Identity: f0 centre tap only, f1 zero, ramp image.
        vecs[0].name = "ident"; vecs[0].w = '0; vecs[0].w[4] = 16'd1;
        vecs[0].ramp = 1'b1; vecs[0].pix = '0; vecs[0].busy_go = 1'b0;
        for (int i = 0; i < 8; i++) vecs[0].exp[i] = 16'(e_id[i]);
        // All ones, with go pulses while busy.
        vecs[1].name = "ones"; vecs[1].ramp = 1'b0; vecs[1].pix = 16'd1; vecs[1].busy_go = 1'b1;
        for (int i = 0; i < 18; i++) vecs[1].w[i] = 16'd1;
        for (int i = 0; i < 8; i++) vecs[1].exp[i] = 16'd9;
        // f0 all -1, f1 all +1 on an all-ones image.
        vecs[2].name = "neg"; vecs[2].ramp = 1'b0; vecs[2].pix = 16'd1; vecs[2].busy_go = 1'b0;
        for (int i = 0; i < 18; i++) vecs[2].w[i] = (i < 9) ? 16'hFFFF : 16'd1;
        for (int i = 0; i < 8; i++) begin
`ifdef CONV_RELU_EN
            vecs[2].exp[i] = (i < 4) ? 16'h0000 : 16'd9;
`else
            vecs[2].exp[i] = (i < 4) ? 16'hFFF7 : 16'd9;
`endif
        end
        // Positive saturation.
        vecs[3].name = "sat"; vecs[3].ramp = 1'b0; vecs[3].pix = 16'h7FFF; vecs[3].busy_go = 1'b0;
        for (int i = 0; i < 18; i++) vecs[3].w[i] = 16'h7FFF;
        for (int i = 0; i < 8; i++) vecs[3].exp[i] = 16'h7FFF;
        // Corner taps: f0 top-left = 1, f1 bottom-right = -2, ramp image.
        vecs[4].name = "corner"; vecs[4].w = '0; vecs[4].w[0] = 16'd1; vecs[4].w[17] = 16'hFFFE;
        vecs[4].ramp = 1'b1; vecs[4].pix = '0; vecs[4].busy_go = 1'b0;
        for (int i = 0; i < 8; i++) vecs[4].exp[i] = 16'(e_cn[i]);

        for (int i = 0; i < 512; i++) begin
            bvm_mem[i] = '0;
            dim_mem[i] = '0;
        end
        for (int i = 0; i < 8; i++) dom_mem[i] = 16'hDEAD;

        reset = 1'b1;
        xxx__dut__go = 1'b0;
        tick();
        tick();
        chk("reset_outputs", {31'd0, idle_bad()}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("idle_%0d", i), {31'd0, idle_bad()}, 32'd0);
        end

        for (int k = 0; k < 5; k++) run_vec(k);

        // Abort in the middle of a quadrant load.
        xxx__dut__go = 1'b1;
        tick();
        xxx__dut__go = 1'b0;
        bound = 0;
        while (!dut__dim__enable && bound < 100) begin
            tick();
            bound++;
        end
        chk("reach_load_q", {31'd0, dut__dim__enable}, 32'd1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk("abort_enables", {29'd0, dut__bvm__enable, dut__dim__enable, dut__dom__enable}, 32'd0);
        chk("abort_finish", {31'd0, dut__xxx__finish}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("abort_idle_%0d", i), {31'd0, idle_bad()}, 32'd0);
        end
        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_pool_top.md
# conv_pool_top

Convolution/max-pool accelerator at the top of the neural-net datapath. On a `go` pulse it reads two 3x3 signed filters from the filter memory (bvm) and an 8x8 signed image from the input memory (dim). Each of the four 4x4 image quadrants is convolved with each filter, ReLU'd and 2x2 max-pooled. The eight results are written to the output memory (dom), and completion is signalled on `finish`.

## Interface
- No parameters; all sizes are fixed constants in the package.
- `clk` in 1: single rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `xxx__dut__go` in 1: one-cycle start pulse, sampled only in IDLE.
- `dut__xxx__finish` out 1: level done flag.
- `dut__bvm__address` out 9: filter memory word address.
- `dut__bvm__enable` out 1: filter memory access enable.
- `dut__bvm__write` out 1: filter memory write; tied 0.
- `dut__bvm__data` out 16: filter memory write data; tied 0.
- `bvm__dut__data` in 16: filter memory read data.
- `dut__dim__address` out 9: input memory word address.
- `dut__dim__enable` out 1: input memory access enable.
- `dut__dim__write` out 1: input memory write; tied 0.
- `dut__dim__data` out 16: input memory write data; tied 0.
- `dim__dut__data` in 16: input memory read data.
- `dut__dom__address` out 3: output memory word address.
- `dut__dom__data` out 16: output memory write data.
- `dut__dom__enable` out 1: output memory access enable.
- `dut__dom__write` out 1: output memory write strobe.

## Operation
- Memory map:
  - Filter f (0..1) occupies bvm words 9f..9f+8, row-major.
  - Image occupies dim words 0..63, addr = row*8+col.
  - Result for filter f, quadrant q lands at dom word 4f+q.
- Quadrant q (0..3) covers rows 4*(q>>1)..+3 and cols 4*(q&1)..+3.
- FSM states:
  - IDLE: waits for go.
  - LOAD_W: reads 18 weights into the weight cache.
  - LOAD_Q: reads the 16 words of the current quadrant into the input cache.
  - COMPUTE: for each filter, computes the 4 valid 3x3 convolution outputs, then the 2x2 max.
  - WRITE: two dom writes for the quadrant, filter 0 then filter 1.
  - NEXT: increments `input_quadrant_index`; after quadrant 3 goes to DONE, otherwise to LOAD_Q.
  - DONE: sets finish, then returns to IDLE.
- Arithmetic:
  - 16x16 signed products.
  - 9-term sum accumulated in 36 bits.
  - ReLU per conv output (see Configuration), then max of the four.
  - Result saturated to signed 16-bit (0x7FFF / 0x8000).
- `a0_cached` flag is set once the current quadrant's top-left pixel is resident in the cache. It clears on quadrant change.
- `go` outside IDLE is ignored.
- `reset` mid-run aborts immediately to IDLE; no further memory accesses occur.

## Timing
- Reset values: all addresses 0, all enables/writes 0, `dut__dom__data` 0, finish 0, FSM IDLE, `input_quadrant_index` 0.
- Memory reads: synchronous, 1-cycle latency. Address+enable driven in cycle N; data captured at the end of cycle N+1. Reads are pipelined, one address per cycle.
- Stage timing:
  - LOAD_W: 18 + 1 cycles.
  - LOAD_Q: 16 + 1 cycles.
  - COMPUTE: at most 8 cycles per quadrant; one conv output per cycle, with pooling folded in.
  - WRITE: exactly one cycle per output, with enable=write=1.
- Total run from go to finish: at most 140 cycles.
- Finish behaviour:
  - Rises the cycle after the last dom write.
  - Stays 1 until the cycle after the next accepted go, when it drops.

## Configuration
- `CONV_RELU_EN` defined: negative conv outputs are clamped to 0 before pooling, so all results are ≥ 0.
- `CONV_RELU_EN` undefined: raw signed max-pool; results may be negative.

## Structure
- Package `conv_pkg` holds:
  - Widths: DATA_W=16, ADDR_W=9, OUT_ADDR_W=3, ACC_W=36.
  - Geometry: IMG_DIM=8, Q_DIM=4, K_DIM=3, NUM_FILTERS=2.
  - Base addresses.
  - The FSM state enum.
- One sub-module, `input_cache`:
  - Instance name m2.
  - Holds the 16-word quadrant register file.
  - Exposes `input_quadrant_index` and `a0_cached`.
  - Generates dim addresses.
- `filter_ram` is a separate bench memory model, not part of this block:
  - Interface: clock, enable, address[8:0], write, write_data[15:0], read_data[15:0].
  - Synchronous 1-cycle read, 512x16.

## Test plan
- Reset then no go:
  - All outputs hold reset values for 20 cycles.
  - No enable asserted.
- Identity filters, image(r,c)=r*8+c:
  - Stimulus: f0 center=1, f1 all 0.
  - dom[0..3] = 18, 22, 50, 54.
  - dom[4..7] = 0.
- All-ones filters with all-ones image:
  - Every output = 9.
  - Finish rises ≤ 140 cycles after go.
- Negative filter f0 = all -1, image all 1:
  - With `CONV_RELU_EN`: dom[0..3] = 0.
  - Without it: dom[0..3] = -9 (0xFFF7).
- Saturation, weights and pixels 0x7FFF:
  - Outputs = 0x7FFF.
- Reset asserted mid-LOAD_Q:
  - All enables 0 the next cycle; finish 0.
  - A fresh go reruns correctly.
- go pulsed while busy:
  - Ignored; exactly 8 dom writes per run.
